// File: rtl/weight_memory_pkg.sv
// weight_memory_pkg: shared constants, grant encoding and address-width helper for the weight SRAM arbiter
package weight_memory_pkg;
    localparam int RSP_FIFO_DEPTH = 2;
    typedef enum logic [1:0] {GRANT_NONE, GRANT_READ, GRANT_WRITE} grant_t;
    function automatic int addr_width(input int rows);
        return rows > 1 ? $clog2(rows) : 1;
    endfunction
endpackage

// File: rtl/weight_memory_arbiter_if.sv
// weight_memory_arbiter_if: write request, read request and read response channels of the weight SRAM arbiter
interface weight_memory_arbiter_if import weight_memory_pkg::*; #(
    parameter int WIDTH = 1024,
    parameter int NUM_ROWS = 128
);
    localparam int ADDRESS_WIDTH = addr_width(NUM_ROWS);
    logic wr_valid;
    logic wr_ready;
    logic [ADDRESS_WIDTH-1:0] wr_address;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] wr_mask;
    logic rd_valid;
    logic rd_ready;
    logic [ADDRESS_WIDTH-1:0] rd_address;
    logic rsp_valid;
    logic rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    modport master(
        output wr_valid, wr_address, wr_data, wr_mask, rd_valid, rd_address, rsp_ready,
        input wr_ready, rd_ready, rsp_valid, rsp_data
    );
    modport slave(
        input wr_valid, wr_address, wr_data, wr_mask, rd_valid, rd_address, rsp_ready,
        output wr_ready, rd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/weight_memory_arbiter_rsp_fifo.sv
// weight_rsp_fifo: 2-entry valid/ready buffer for SRAM read data, exposing occupancy for read credit
module weight_rsp_fifo import weight_memory_pkg::*; #(
    parameter int WIDTH = 1024,
    localparam int COUNT_WIDTH = $clog2(RSP_FIFO_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [COUNT_WIDTH-1:0] occupancy
);
    logic [WIDTH-1:0] mem [RSP_FIFO_DEPTH];
    logic wr_ptr;
    logic rd_ptr;
    logic pop;
    assign out_valid = occupancy != '0;
    assign pop = out_valid && out_ready;
    assign out_data = mem[rd_ptr];
    // pointer and count update; upstream credit guarantees no push while full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occupancy <= '0;
        end else begin
            wr_ptr <= wr_ptr ^ push;
            rd_ptr <= rd_ptr ^ pop;
            occupancy <= occupancy + COUNT_WIDTH'(push) - COUNT_WIDTH'(pop);
        end
    end
    // storage words carry no reset; only the pointers decide what is valid
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/weight_memory_arbiter.sv
// weight_memory_arbiter: read-priority arbiter driving the weight SRAM; WEIGHT_ARB_STARVE_GUARD_EN adds write-starvation guard
module weight_memory_arbiter import weight_memory_pkg::*; #(
    parameter int WIDTH = 1024,
    parameter int NUM_ROWS = 128,
    parameter int MAX_WAIT = 8,
    localparam int ADDRESS_WIDTH = addr_width(NUM_ROWS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    weight_memory_arbiter_if.slave   bus,
    output logic                     sram_chip_select,
    output logic                     sram_write_enable,
    output logic [ADDRESS_WIDTH-1:0] sram_address,
    output logic [WIDTH-1:0]         sram_data_in,
    output logic [WIDTH-1:0]         sram_mask,
    input  logic [WIDTH-1:0]         sram_data_out
);
    localparam int COUNT_WIDTH = $clog2(RSP_FIFO_DEPTH + 1);
    grant_t grant;
    logic inflight;
    logic write_first;
    logic credit;
    logic [COUNT_WIDTH-1:0] occupancy;
    logic [ADDRESS_WIDTH-1:0] held_address;
    logic [WIDTH-1:0] held_data;
    logic [WIDTH-1:0] held_mask;
`ifdef WEIGHT_ARB_STARVE_GUARD_EN
    localparam int WAIT_WIDTH = $clog2(MAX_WAIT + 1);
    logic [WAIT_WIDTH-1:0] wait_count;
    assign write_first = bus.wr_valid && wait_count >= WAIT_WIDTH'(MAX_WAIT);
    // cycles a pending write has been refused, saturating at the threshold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wait_count <= '0;
        else if (grant == GRANT_WRITE) wait_count <= '0;
        else if (bus.wr_valid && wait_count < WAIT_WIDTH'(MAX_WAIT)) wait_count <= wait_count + 1'b1;
    end
`else
    assign write_first = 1'b0;
`endif
    // a read may issue only if buffered, in-flight and the new read still fit once this cycle's pop leaves
    assign credit = 3'(occupancy) + 3'(inflight) < 3'(RSP_FIFO_DEPTH) + 3'(bus.rsp_valid && bus.rsp_ready);
    // choose the winner and drive the SRAM pins; with no grant the pins keep their last value
    always_comb begin
        grant = !rst_n ? GRANT_NONE
              : bus.rd_valid && !write_first && credit ? GRANT_READ
              : bus.wr_valid ? GRANT_WRITE : GRANT_NONE;
        bus.rd_ready = grant == GRANT_READ;
        bus.wr_ready = grant == GRANT_WRITE;
        sram_chip_select = grant == GRANT_NONE;
        sram_write_enable = grant != GRANT_WRITE;
        sram_address = grant == GRANT_READ ? bus.rd_address : grant == GRANT_WRITE ? bus.wr_address : held_address;
        sram_data_in = grant == GRANT_WRITE ? bus.wr_data : held_data;
        sram_mask = grant == GRANT_WRITE ? bus.wr_mask : held_mask;
    end
    // last driven pin values, and a flag that the SRAM returns read data next cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
            held_address <= '0;
            held_data <= '0;
            held_mask <= '0;
        end else begin
            inflight <= grant == GRANT_READ;
            held_address <= sram_address;
            held_data <= sram_data_in;
            held_mask <= sram_mask;
        end
    end
    weight_rsp_fifo #(.WIDTH(WIDTH)) u_rsp_fifo (
        .clk(clk),
        .rst_n(rst_n),
        .push(inflight),
        .push_data(sram_data_out),
        .out_valid(bus.rsp_valid),
        .out_ready(bus.rsp_ready),
        .out_data(bus.rsp_data),
        .occupancy(occupancy)
    );
endmodule

// File: tb/tb_weight_memory_arbiter.sv
// tb_weight_memory_arbiter: randomized and directed traffic checked against a queue-based model of the arbiter
module tb_weight_memory_arbiter;
    localparam int W = 32;
    localparam int R = 16;
    localparam int AW = 4;
    localparam int MW = 8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    weight_memory_arbiter_if #(.WIDTH(W), .NUM_ROWS(R)) bus();
    logic cs, we;
    logic [AW-1:0] sa;
    logic [W-1:0] sd, sm, sq;
    weight_memory_arbiter #(.WIDTH(W), .NUM_ROWS(R), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .sram_chip_select(cs), .sram_write_enable(we), .sram_address(sa),
        .sram_data_in(sd), .sram_mask(sm), .sram_data_out(sq)
    );
    // single-port SRAM with one-cycle read latency
    logic [W-1:0] smem [R];
    always @(posedge clk) begin
        if (!cs) begin
            if (!we) smem[sa] <= (smem[sa] & ~sm) | (sd & sm);
            else sq <= smem[sa];
        end
    end
    typedef struct { int avail; logic [W-1:0] d; } rsp_t;
    rsp_t q[$];
    logic [W-1:0] rmem [R];
    int cyc = 0, checks = 0, failures = 0, wcnt = 0;
    logic [AW-1:0] la;
    logic [W-1:0] ld, lm;
    bit la_ok = 0, ld_ok = 0;
    task automatic chk(input string n, input logic [W-1:0] a, input logic [W-1:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", n, cyc, a, e);
        end
    endtask
    // reference model: responses are a queue of (ready cycle, data captured at accept)
    always @(negedge clk) begin
        int occ;
        bit infl, vld, pop, erd, ewr, wpri;
        if (!rst_n) begin
            q.delete();
            la_ok = 0;
            ld_ok = 0;
            wcnt = 0;
            chk("rst_rd_ready", W'(bus.rd_ready), 0);
            chk("rst_wr_ready", W'(bus.wr_ready), 0);
            chk("rst_rsp_valid", W'(bus.rsp_valid), 0);
            chk("rst_cs", W'(cs), 1);
            chk("rst_we", W'(we), 1);
        end else begin
            occ = 0;
            infl = 0;
            foreach (q[i]) if (q[i].avail <= cyc) occ++; else infl = 1;
            vld = occ > 0;
            pop = vld && bus.rsp_ready;
`ifdef WEIGHT_ARB_STARVE_GUARD_EN
            wpri = bus.wr_valid && wcnt >= MW;
`else
            wpri = 0;
`endif
            erd = bus.rd_valid && !wpri && (occ + int'(infl) - int'(pop) < 2);
            ewr = bus.wr_valid && !erd;
            chk("rd_ready", W'(bus.rd_ready), W'(erd));
            chk("wr_ready", W'(bus.wr_ready), W'(ewr));
            chk("rsp_valid", W'(bus.rsp_valid), W'(vld));
            chk("cs", W'(cs), W'(!(erd || ewr)));
            chk("we", W'(we), W'(!ewr));
            if (vld) chk("rsp_data", bus.rsp_data, q[0].d);
            if (erd) chk("rd_addr", W'(sa), W'(bus.rd_address));
            if (ewr) begin
                chk("wr_addr", W'(sa), W'(bus.wr_address));
                chk("wr_data", sd, bus.wr_data);
                chk("wr_mask", sm, bus.wr_mask);
            end
            if (!erd && !ewr && la_ok) chk("hold_addr", W'(sa), W'(la));
            if (!erd && !ewr && ld_ok) begin
                chk("hold_data", sd, ld);
                chk("hold_mask", sm, lm);
            end
            if (pop) void'(q.pop_front());
            if (erd) begin
                q.push_back('{cyc + 2, rmem[bus.rd_address]});
                la = bus.rd_address;
                la_ok = 1;
            end
            if (ewr) begin
                rmem[bus.wr_address] = (rmem[bus.wr_address] & ~bus.wr_mask) | (bus.wr_data & bus.wr_mask);
                la = bus.wr_address;
                ld = bus.wr_data;
                lm = bus.wr_mask;
                la_ok = 1;
                ld_ok = 1;
                wcnt = 0;
            end else if (bus.wr_valid) wcnt++;
        end
        cyc++;
    end
    task automatic nx();
        @(posedge clk);
        #1;
    endtask
    task automatic set(input bit rv, input logic [AW-1:0] ra, input bit wv, input logic [AW-1:0] wa,
                       input logic [W-1:0] wd, input logic [W-1:0] wm, input bit rr);
        bus.rd_valid = rv;
        bus.rd_address = ra;
        bus.wr_valid = wv;
        bus.wr_address = wa;
        bus.wr_data = wd;
        bus.wr_mask = wm;
        bus.rsp_ready = rr;
    endtask
    initial begin
        int n, m;
        set(0, 0, 0, 0, 0, 0, 1);
        repeat (3) nx();
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n += int'(cs) + int'(!bus.rsp_valid);
            nx();
        end
        chk("idle_10", W'(n), 20);
        for (int r = 0; r < R; r++) begin
            set(0, 0, 1, AW'(r), $urandom, '1, 1);
            nx();
        end
        set(0, 0, 1, 5, 32'hA5A5A5A5, '1, 1);
        nx();
        set(1, 5, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("rd5_accept", W'(bus.rd_ready), 1);
        nx();
        set(0, 0, 1, 5, 32'h5A5A5A5A, '1, 1);
        @(negedge clk);
        chk("rd5_n1_valid", W'(bus.rsp_valid), 0);
        chk("wr_after_rd", W'(bus.wr_ready), 1);
        nx();
        set(0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("rd5_n2_valid", W'(bus.rsp_valid), 1);
        chk("rd5_n2_data", bus.rsp_data, 32'hA5A5A5A5);
        nx();
        set(1, 5, 0, 0, 0, 0, 1);
        nx();
        set(0, 0, 0, 0, 0, 0, 1);
        nx();
        @(negedge clk);
        chk("rd5_new_data", bus.rsp_data, 32'h5A5A5A5A);
        nx();
        repeat (2) nx();
        n = 0;
        m = 0;
        for (int i = 0; i < 19; i++) begin
            set(i < 16, AW'(i), 0, 0, 0, 0, 1);
            @(negedge clk);
            n += int'(bus.rd_ready);
            m += int'(bus.rsp_valid);
            nx();
        end
        chk("b2b_accepts", W'(n), 16);
        chk("b2b_responses", W'(m), 16);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            set(1, AW'($urandom), 0, 0, 0, 0, 0);
            @(negedge clk);
            n += int'(bus.rd_ready);
            nx();
        end
        chk("stall_accepts", W'(n), 2);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            set(0, 0, 0, 0, 0, 0, 1);
            @(negedge clk);
            n += int'(bus.rsp_valid);
            nx();
        end
        chk("stall_drain", W'(n), 2);
        n = 0;
        for (int i = 0; i < 3; i++) begin
            set(1, AW'(i), 0, 0, 0, 0, 1);
            @(negedge clk);
            n += int'(bus.rd_ready);
            nx();
        end
        chk("resume_accepts", W'(n), 3);
        set(0, 0, 0, 0, 0, 0, 1);
        repeat (3) nx();
        n = 0;
        for (int i = 0; i < 20; i++) begin
            set(1, AW'($urandom), 1, AW'($urandom), $urandom, '1, 1);
            @(negedge clk);
            n += int'(bus.wr_ready);
            nx();
        end
`ifdef WEIGHT_ARB_STARVE_GUARD_EN
        chk("contend_writes", W'(n), 2);
`else
        chk("contend_writes", W'(n), 0);
`endif
        for (int i = 0; i < 1500; i++) begin
            set($urandom_range(0, 3) != 0, AW'($urandom), $urandom_range(0, 2) == 0, AW'($urandom),
                $urandom, $urandom, $urandom_range(0, 3) != 0);
            nx();
        end
        set(1, 2, 0, 0, 0, 0, 0);
        repeat (3) nx();
        rst_n = 1'b0;
        repeat (2) nx();
        rst_n = 1'b1;
        set(0, 0, 0, 0, 0, 0, 1);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n += int'(bus.rsp_valid);
            nx();
        end
        chk("post_reset_no_rsp", W'(n), 0);
        set(1, 3, 0, 0, 0, 0, 1);
        nx();
        set(0, 0, 0, 0, 0, 0, 1);
        repeat (4) nx();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/weight_memory_arbiter.md
# weight_memory_arbiter

Arbitrates the single-port weight SRAM (`weight_memory`) between a write requester (weight loader) and a read requester (compute engine). It drives the SRAM's active-low chip-select and write-enable. Read data is returned through a buffered valid/ready response channel so the compute side can stall without losing data. The block sits directly in front of `weight_memory`, and is the only logic that drives it.

## Interface
Parameters:
- `WIDTH`, 1024: SRAM word width in bits.
- `NUM_ROWS`, 128: SRAM depth; `ADDRESS_WIDTH = $clog2(NUM_ROWS)` (localparam).
- `MAX_WAIT`, 8: write-starvation threshold in cycles. Used only with `WEIGHT_ARB_STARVE_GUARD_EN`.

Ports (clock and reset first):
- `clk` in 1: single clock; all state is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `wr_valid` in 1, `wr_ready` out 1: write request handshake.
- `wr_address` in ADDRESS_WIDTH, `wr_data` in WIDTH, `wr_mask` in WIDTH: write payload. The mask is passed to the SRAM unchanged.
- `rd_valid` in 1, `rd_ready` out 1, `rd_address` in ADDRESS_WIDTH: read request handshake.
- `rsp_valid` out 1, `rsp_ready` in 1, `rsp_data` out WIDTH: read response handshake.
- `sram_chip_select` out 1: active-low; connects to `weight_memory.chip_select`.
- `sram_write_enable` out 1: active-low; connects to `write_enable`.
- `sram_address` out ADDRESS_WIDTH, `sram_data_in` out WIDTH, `sram_mask` out WIDTH: SRAM request signals.
- `sram_data_out` in WIDTH: SRAM Q output.

## Operation
- A request transfers when valid and ready are both high in the same cycle. The SRAM is driven combinationally from the granted request in that same cycle.
- Read credit rule: `rd_ready = rd_valid_ok && (occupancy + inflight - (rsp_valid && rsp_ready)) < 2`.
  - `occupancy` is the response FIFO count (depth 2).
  - `inflight` is 1 if a read was issued in the previous cycle, else 0.
- Default priority is read over write. Behaviour per cycle:
  - Only `rd_valid`: grant the read if credit allows.
  - Only `wr_valid`: always grant the write.
  - Both: grant the read if credit allows; otherwise grant the write.
- Read grant: `sram_chip_select=0`, `sram_write_enable=1`, `sram_address=rd_address`.
- Write grant: `sram_chip_select=0`, `sram_write_enable=0`, address, data and mask taken from the write port.
- No grant: `sram_chip_select=1`, `sram_write_enable=1`. Address, data and mask are don't-care but must be held stable at their last value, so the SRAM pins do not toggle.
- Read response: the read issued in cycle N samples `sram_data_out` at the end of cycle N+1 and pushes it into the FIFO. `rsp_valid` rises in cycle N+2 and `rsp_data` is the FIFO head.
- Ordering: responses are returned in request order. A write to address A granted after a read of A does not affect that read's data.
- Reset mid-operation clears the FIFO and the inflight flag. Any read in flight is dropped and no response is produced for it.
- Reset values: `rsp_valid=0`, `sram_chip_select=1`, `sram_write_enable=1`, `wr_ready=0`, `rd_ready=0`, FIFO empty, wait counter 0.

## Timing
- Read latency: request accepted in cycle N, earliest `rsp_valid` in cycle N+2.
- Throughput: one read per cycle sustained while `rsp_ready=1`.
- With `rsp_ready=0`, at most 2 reads are outstanding, then `rd_ready` drops.
- Writes complete in the grant cycle. There is no write response.
- `wr_ready` and `rd_ready` depend combinationally on valid inputs and internal state. They never depend on `rsp_data`.
- Once `rsp_valid` is high, `rsp_valid` and `rsp_data` stay stable until `rsp_ready` is seen.

## Configuration
- `WEIGHT_ARB_STARVE_GUARD_EN` defined:
  - A wait counter increments in every cycle with `wr_valid && !wr_ready`, and clears on a write grant.
  - When the counter reaches `MAX_WAIT`, the write has priority over the read in the next cycle where `wr_valid` is high.
  - Worst-case write wait is `MAX_WAIT+1` cycles.
- Not defined: strict read priority. The counter and the `MAX_WAIT` logic are absent.

## Structure
- Package `weight_memory_pkg` holds:
  - `RSP_FIFO_DEPTH = 2`.
  - Typedef `grant_t` enum with values `GRANT_NONE`, `GRANT_READ`, `GRANT_WRITE`.
  - The address-width helper function.
- Sub-module `weight_rsp_fifo`: 2-entry, WIDTH-bit, valid/ready FIFO with an occupancy output used by the credit logic.
- The arbiter top level contains the grant logic, the inflight flag, the optional wait counter, and the SRAM pin drive.

## Test plan
- Reset then idle: `sram_chip_select=1`, `rsp_valid=0` for 10 cycles. Assert `rst_n` low mid-burst: FIFO is cleared and no stale `rsp_valid` follows.
- Write row 5 with `0xA5…`, full mask, then read row 5: `rsp_data=0xA5…` appears exactly 2 cycles after the read handshake.
- Back-to-back reads of rows 0–15 with `rsp_ready=1`: 16 consecutive `rd_ready` cycles; responses arrive in order, one per cycle.
- `rsp_ready=0` while reading: `rd_ready` drops after 2 accepts. Raising `rsp_ready` drains both responses in order and reads resume.
- `wr_valid` and `rd_valid` both held high with `rsp_ready=1`: reads always win and no write is granted (guard undefined).
- Same stimulus with `WEIGHT_ARB_STARVE_GUARD_EN` and `MAX_WAIT=8`: a write is granted at the latest 9 cycles after `wr_valid` rises, and the counter then restarts.
